// File: rtl/mult_pool_alloc.sv
// Multiplier pool allocator: grants free multiplier indices one per handshake,
// lowest free first, and tracks pool occupancy with release handling.
module mult_pool_alloc #(
    parameter int NMULT = 64,
    parameter int IDW   = 6,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    input  logic [CNTW-1:0]  req_count,
    output logic             req_ready,
    input  logic             abort,
    output logic             grant_valid,
    input  logic             grant_ready,
    output logic [IDW-1:0]   grant_idx,
    output logic             grant_last,
    output logic             done,
    output logic             aborted,
    input  logic             rel_valid,
    input  logic [IDW-1:0]   rel_idx,
    output logic [NMULT-1:0] busy_map,
    output logic [IDW:0]     free_count,
    output logic             rel_err
);

    typedef enum logic [1:0] {IDLE, SCAN, STALL} state_t;

    state_t           state;
    logic [CNTW-1:0]  remaining;
    logic             rel_in, rel_ok, rel_bad, grant_fire, full_next;
    logic [NMULT-1:0] grant_mask, rel_mask, map_next;
    logic [IDW-1:0]   nxt_idx;

    assign req_ready   = (state == IDLE);
    assign grant_valid = (state == SCAN);

    // abort wins over a handshake in the same cycle
    assign grant_fire = (state == SCAN) && grant_ready && !abort;
    assign rel_in     = ({1'b0, rel_idx} < (IDW+1)'(NMULT));
    assign rel_ok     = rel_valid && rel_in && busy_map[rel_idx];
    assign rel_bad    = rel_valid && !rel_ok;

    // Map as it will be after this edge; the next offered index is taken from it
    // so a release at this edge is grantable in the very next cycle.
    always_comb begin
        grant_mask = '0;
        rel_mask   = '0;
        if (grant_fire) grant_mask[grant_idx] = 1'b1;
        if (rel_ok)     rel_mask[rel_idx]     = 1'b1;
        map_next = (busy_map | grant_mask) & ~rel_mask;
        nxt_idx  = '0;
        for (int i = NMULT - 1; i >= 0; i--)
            if (!map_next[i]) nxt_idx = IDW'(i);
    end

    assign full_next = &map_next;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            remaining  <= '0;
            busy_map   <= '0;
            free_count <= (IDW+1)'(NMULT);
            grant_idx  <= '0;
            grant_last <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            rel_err    <= 1'b0;
        end else begin
            busy_map   <= map_next;
            free_count <= free_count + (IDW+1)'(rel_ok) - (IDW+1)'(grant_fire);
            done       <= 1'b0;
            aborted    <= 1'b0;
            if (rel_bad) rel_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        remaining <= req_count;
                        if (req_count == '0) begin
                            done <= 1'b1;
                        end else if (full_next) begin
                            state <= STALL;
                        end else begin
                            state      <= SCAN;
                            grant_idx  <= nxt_idx;
                            grant_last <= (req_count == CNTW'(1));
                        end
                    end
                end
                SCAN: begin
                    if (abort) begin
                        state      <= IDLE;
                        aborted    <= 1'b1;
                        grant_last <= 1'b0;
                    end else if (grant_fire) begin
                        remaining <= remaining - CNTW'(1);
                        if (remaining == CNTW'(1)) begin
                            state      <= IDLE;
                            done       <= 1'b1;
                            grant_last <= 1'b0;
                        end else if (full_next) begin
                            state      <= STALL;
                            grant_last <= 1'b0;
                        end else begin
                            grant_idx  <= nxt_idx;
                            grant_last <= (remaining == CNTW'(2));
                        end
                    end
                end
                STALL: begin
                    if (abort) begin
                        state   <= IDLE;
                        aborted <= 1'b1;
                    end else if (!full_next) begin
                        state      <= SCAN;
                        grant_idx  <= nxt_idx;
                        grant_last <= (remaining == CNTW'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_pool_alloc.sv
// Bench for mult_pool_alloc: directed scenarios then random traffic, all
// checked every cycle against a pool/batch model built from plain arrays.
module tb_mult_pool_alloc;

    localparam int NM = 64;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic [15:0] req_count;
    logic        req_ready;
    logic        abort;
    logic        grant_valid;
    logic        grant_ready;
    logic [5:0]  grant_idx;
    logic        grant_last;
    logic        done;
    logic        aborted;
    logic        rel_valid;
    logic [5:0]  rel_idx;
    logic [63:0] busy_map;
    logic [6:0]  free_count;
    logic        rel_err;

    mult_pool_alloc #(.NMULT(64), .IDW(6), .CNTW(16)) dut (
        .clk(clk), .rstn(rstn),
        .req_valid(req_valid), .req_count(req_count), .req_ready(req_ready),
        .abort(abort),
        .grant_valid(grant_valid), .grant_ready(grant_ready),
        .grant_idx(grant_idx), .grant_last(grant_last),
        .done(done), .aborted(aborted),
        .rel_valid(rel_valid), .rel_idx(rel_idx),
        .busy_map(busy_map), .free_count(free_count), .rel_err(rel_err)
    );

    always #5 clk = ~clk;

    int nchk = 0;
    int nerr = 0;

    // model: occupancy per slot, batch activity, outstanding count, held offer
    bit   mbusy[NM];
    bit   mact, mhold, merr, mdone, mab, m_offer;
    int   mrem;
    int   midx;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int lowest_free();
        for (int i = 0; i < NM; i++) if (!mbusy[i]) return i;
        return -1;
    endfunction

    function automatic int nfree();
        int n = 0;
        for (int i = 0; i < NM; i++) if (!mbusy[i]) n++;
        return n;
    endfunction

    function automatic logic [63:0] mmap();
        logic [63:0] m;
        for (int i = 0; i < NM; i++) m[i] = mbusy[i];
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NM; i++) mbusy[i] = 1'b0;
        mact = 0; mhold = 0; merr = 0; mdone = 0; mab = 0; m_offer = 0;
        mrem = 0; midx = 0;
    endtask

    task automatic check_all();
        bit offer;
        offer = mact && (nfree() > 0);
        if (offer && !mhold) midx = lowest_free();
        chk("req_ready", 64'(req_ready), 64'(!mact));
        chk("grant_valid", 64'(grant_valid), 64'(offer));
        if (offer) begin
            chk("grant_idx", 64'(grant_idx), 64'(midx));
            chk("grant_last", 64'(grant_last), 64'(mrem == 1));
        end
        chk("done", 64'(done), 64'(mdone));
        chk("aborted", 64'(aborted), 64'(mab));
        chk("busy_map", busy_map, mmap());
        chk("free_count", 64'(free_count), 64'(nfree()));
        chk("rel_err", 64'(rel_err), 64'(merr));
        m_offer = offer;
    endtask

    task automatic model_update();
        bit take;
        take  = m_offer && grant_ready && !abort;
        mdone = 0;
        mab   = 0;
        if (rel_valid) begin
            if (mbusy[rel_idx]) mbusy[rel_idx] = 1'b0;
            else merr = 1'b1;
        end
        mhold = 0;
        if (!mact) begin
            if (req_valid) begin
                if (req_count == 0) mdone = 1;
                else begin mact = 1; mrem = int'(req_count); end
            end
        end else if (abort) begin
            mact = 0;
            mab  = 1;
        end else if (take) begin
            mbusy[midx] = 1'b1;
            mrem--;
            if (mrem == 0) begin mact = 0; mdone = 1; end
        end else if (m_offer) begin
            mhold = 1;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_count = 0; abort = 0; rel_valid = 0; rel_idx = 0;
    endtask

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 200 && mact; k++) cyc();
        chk(tag, 64'(req_ready), 64'd1);
    endtask

    initial begin
        idle_inputs();
        grant_ready = 1;
        rstn = 0;
        model_reset();
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        chk("rst_grant_last", 64'(grant_last), 64'd0);
        chk("rst_free_count", 64'(free_count), 64'd64);
        @(negedge clk);
        rstn = 1;
        check_all();

        // request 3 with consumer always ready
        req_valid = 1; req_count = 3;
        cyc();
        req_valid = 0;
        chk("b3_first_idx", 64'(grant_idx), 64'd0);
        cyc(); cyc();
        chk("b3_last_flag", 64'(grant_last), 64'd1);
        cyc();
        chk("b3_done", 64'(done), 64'd1);
        chk("b3_map", busy_map, 64'h7);
        chk("b3_free", 64'(free_count), 64'd61);

        // release 1, then a single grant reuses it
        rel_valid = 1; rel_idx = 1;
        cyc();
        rel_valid = 0; req_valid = 1; req_count = 1;
        cyc();
        req_valid = 0;
        chk("reuse_idx", 64'(grant_idx), 64'd1);
        chk("reuse_last", 64'(grant_last), 64'd1);
        cyc();
        chk("reuse_map", busy_map, 64'h7);

        // fill pool, then stall a batch of 2 and feed it by releases
        req_valid = 1; req_count = 61;
        cyc();
        req_valid = 0;
        wait_idle("fill_timeout");
        chk("full_free", 64'(free_count), 64'd0);
        req_valid = 1; req_count = 2;
        cyc();
        req_valid = 0;
        chk("stall_gv", 64'(grant_valid), 64'd0);
        cyc();
        rel_valid = 1; rel_idx = 10;
        cyc();
        rel_valid = 0;
        chk("resume_idx10", 64'(grant_idx), 64'd10);
        cyc();
        chk("restall_gv", 64'(grant_valid), 64'd0);
        rel_valid = 1; rel_idx = 5;
        cyc();
        rel_valid = 0;
        chk("resume_idx5", 64'(grant_idx), 64'd5);
        chk("resume_last", 64'(grant_last), 64'd1);
        cyc();
        chk("stall_done", 64'(done), 64'd1);

        // hold with grant_ready low while a lower index is released
        rel_valid = 1; rel_idx = 20; cyc();
        rel_idx = 30; cyc();
        rel_valid = 0; grant_ready = 0; req_valid = 1; req_count = 2;
        cyc();
        req_valid = 0;
        chk("hold_idx0", 64'(grant_idx), 64'd20);
        rel_valid = 1; rel_idx = 3;
        cyc();
        rel_valid = 0;
        chk("hold_idx1", 64'(grant_idx), 64'd20);
        cyc();
        chk("hold_idx2", 64'(grant_idx), 64'd20);
        grant_ready = 1;
        cyc();
        chk("after_hold_idx", 64'(grant_idx), 64'd3);
        cyc();

        // zero-length request
        req_valid = 1; req_count = 0;
        cyc();
        req_valid = 0;
        chk("zero_gv", 64'(grant_valid), 64'd0);
        chk("zero_done", 64'(done), 64'd1);
        chk("zero_ready", 64'(req_ready), 64'd1);
        cyc();

        // release of a free index
        rel_valid = 1; rel_idx = 40; cyc();
        chk("rel_ok_noerr", 64'(rel_err), 64'd0);
        cyc();
        rel_valid = 0;
        chk("rel_free_err", 64'(rel_err), 64'd1);

        // abort while stalled
        req_valid = 1; req_count = 2; cyc();
        req_valid = 0;
        wait_idle("refill_timeout");
        req_valid = 1; req_count = 1; cyc();
        req_valid = 0;
        chk("abort_stall_gv", 64'(grant_valid), 64'd0);
        abort = 1; cyc();
        abort = 0;
        chk("abort_pulse", 64'(aborted), 64'd1);
        chk("abort_ready", 64'(req_ready), 64'd1);
        chk("abort_map", busy_map, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();

        // reset during a held grant
        rel_valid = 1; rel_idx = 7; cyc();
        rel_valid = 0; grant_ready = 0; req_valid = 1; req_count = 3;
        cyc();
        req_valid = 0;
        chk("pre_rst_gv", 64'(grant_valid), 64'd1);
        #2 rstn = 0;
        #1;
        chk("mid_rst_map", busy_map, 64'd0);
        chk("mid_rst_gv", 64'(grant_valid), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        chk("mid_rst_err", 64'(rel_err), 64'd0);
        chk("mid_rst_free", 64'(free_count), 64'd64);
        model_reset();
        @(negedge clk);
        rstn = 1;
        check_all();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            int r;
            req_valid   = ($urandom_range(0, 3) == 0);
            req_count   = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(60, 80))
                                                      : 16'($urandom_range(0, 6));
            grant_ready = ($urandom_range(0, 3) != 0);
            abort       = ($urandom_range(0, 49) == 0);
            rel_valid   = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, NM - 1);
            rel_idx = 6'(r);
            if ($urandom_range(0, 19) != 0) begin
                for (int k = 0; k < NM; k++) begin
                    if (mbusy[(r + k) % NM]) begin
                        rel_idx = 6'((r + k) % NM);
                        break;
                    end
                end
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
